// File: rtl/rc4_stream_core.sv
// RC4 stream cipher engine with ap_ctrl_hs control and ap_fifo data ports.
// Define RC4_DROP_EN to discard DROP_N keystream bytes before encrypting (RC4-drop[N]).
module rc4_stream_core #(
  parameter int unsigned KEY_MAX = 256,
  parameter int unsigned DROP_N  = 256
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [15:0] key_size_in,
  input  logic [31:0] plaintext_size_in,
  input  logic [7:0]  key_in_V_dout,
  input  logic        key_in_V_empty_n,
  output logic        key_in_V_read,
  input  logic [7:0]  plaintext_in_V_dout,
  input  logic        plaintext_in_V_empty_n,
  output logic        plaintext_in_V_read,
  output logic [7:0]  ciphertext_out_V_din,
  input  logic        ciphertext_out_V_full_n,
  output logic        ciphertext_out_V_write
);

  localparam int unsigned KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

`ifdef RC4_DROP_EN
  localparam int unsigned DROP_STEPS = DROP_N;
`else
  // Plain RC4: the discard phase is never entered.
  localparam int unsigned DROP_STEPS = DROP_N * 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_INIT_S, S_KSA, S_DROP, S_PRGA_SWAP, S_PRGA_OUT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d, j_q, j_d;
  logic [KW-1:0] kidx_q, kidx_d;
  logic [15:0] kcnt_q, kcnt_d;
  logic [15:0] key_size_q, key_size_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] pt_size_q, pt_size_d;
  logic [15:0] dcnt_q, dcnt_d;

  logic [7:0]  sbox_q [256];
  logic [7:0]  kbuf_q [KEY_MAX];

  logic        s_we_a, s_we_b, k_we;
  logic [7:0]  s_addr_a, s_addr_b, s_data_a, s_data_b;

  // Combinational S-box taps for KSA, one PRGA step and keystream output
  logic [7:0]  s_i, kb, j_ksa, sj_ksa;
  logic [7:0]  i_nx, si_nx, j_nx, sj_nx;
  logic [7:0]  ks;

  assign s_i    = sbox_q[i_q];
  assign kb     = kbuf_q[kidx_q];
  assign j_ksa  = j_q + s_i + kb;
  assign sj_ksa = sbox_q[j_ksa];
  assign i_nx   = i_q + 8'd1;
  assign si_nx  = sbox_q[i_nx];
  assign j_nx   = j_q + si_nx;
  assign sj_nx  = sbox_q[j_nx];
  assign ks     = sbox_q[8'(sbox_q[i_q] + sbox_q[j_q])];

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    kidx_d     = kidx_q;
    kcnt_d     = kcnt_q;
    key_size_d = key_size_q;
    pcnt_d     = pcnt_q;
    pt_size_d  = pt_size_q;
    dcnt_d     = dcnt_q;
    s_we_a     = 1'b0;
    s_addr_a   = i_q;
    s_data_a   = '0;
    s_we_b     = 1'b0;
    s_addr_b   = j_q;
    s_data_b   = '0;
    k_we       = 1'b0;
    ap_done    = 1'b0;
    ap_ready   = 1'b0;
    ap_idle    = 1'b0;
    key_in_V_read          = 1'b0;
    plaintext_in_V_read    = 1'b0;
    ciphertext_out_V_write = 1'b0;
    ciphertext_out_V_din   = '0;

    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          key_size_d = key_size_in;
          pt_size_d  = plaintext_size_in;
          kcnt_d     = '0;
          pcnt_d     = '0;
          i_d        = '0;
          j_d        = '0;
          kidx_d     = '0;
          if (key_size_in == 16'd0 || 32'(key_size_in) > KEY_MAX) state_d = S_DONE;
          else                                                      state_d = S_LOAD_KEY;
        end
      end
      S_LOAD_KEY: begin
        key_in_V_read = key_in_V_empty_n;
        if (key_in_V_empty_n) begin
          k_we   = 1'b1;
          kcnt_d = kcnt_q + 16'd1;
          if (kcnt_q + 16'd1 == key_size_q) begin
            state_d = S_INIT_S;
            i_d     = '0;
          end
        end
      end
      S_INIT_S: begin
        s_we_a   = 1'b1;
        s_data_a = i_q;
        i_d      = i_nx;
        if (i_q == 8'hFF) begin
          state_d = S_KSA;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      S_KSA: begin
        s_we_a   = 1'b1;
        s_data_a = sj_ksa;
        s_we_b   = 1'b1;
        s_addr_b = j_ksa;
        s_data_b = s_i;
        i_d      = i_nx;
        j_d      = j_ksa;
        kidx_d   = (16'(kidx_q) + 16'd1 == key_size_q) ? '0 : kidx_q + 1'b1;
        if (i_q == 8'hFF) begin
          i_d = '0;
          j_d = '0;
          if (pt_size_q == 32'd0) state_d = S_DONE;
          else if (DROP_STEPS != 0) begin
            state_d = S_DROP;
            dcnt_d  = '0;
          end else state_d = S_PRGA_SWAP;
        end
      end
      S_DROP, S_PRGA_SWAP: begin
        s_we_a   = 1'b1;
        s_addr_a = i_nx;
        s_data_a = sj_nx;
        s_we_b   = 1'b1;
        s_addr_b = j_nx;
        s_data_b = si_nx;
        i_d      = i_nx;
        j_d      = j_nx;
        if (state_q == S_PRGA_SWAP) state_d = S_PRGA_OUT;
        else begin
          dcnt_d = dcnt_q + 16'd1;
          if (32'(dcnt_q) + 32'd1 == DROP_STEPS) state_d = S_PRGA_SWAP;
        end
      end
      S_PRGA_OUT: begin
        // Read and write are issued together so no byte is ever consumed without being emitted
        if (plaintext_in_V_empty_n && ciphertext_out_V_full_n) begin
          plaintext_in_V_read    = 1'b1;
          ciphertext_out_V_write = 1'b1;
          ciphertext_out_V_din   = plaintext_in_V_dout ^ ks;
          pcnt_d                 = pcnt_q + 32'd1;
          if (pcnt_q == pt_size_q - 32'd1) state_d = S_DONE;
          else                             state_d = S_PRGA_SWAP;
        end
      end
      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      kcnt_q     <= '0;
      key_size_q <= '0;
      pcnt_q     <= '0;
      pt_size_q  <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kidx_q     <= kidx_d;
      kcnt_q     <= kcnt_d;
      key_size_q <= key_size_d;
      pcnt_q     <= pcnt_d;
      pt_size_q  <= pt_size_d;
      dcnt_q     <= dcnt_d;
    end
  end

  // S-box and key storage hold data only; a run always rewrites them before use
  always_ff @(posedge ap_clk) begin
    if (s_we_a) sbox_q[s_addr_a] <= s_data_a;
    if (s_we_b) sbox_q[s_addr_b] <= s_data_b;
    if (k_we)   kbuf_q[kcnt_q[KW-1:0]] <= key_in_V_dout;
  end

endmodule
